// File: rtl/lsu_ctrl_if.sv
// Request, data-bus and writeback signals of the load/store sequencer.
// The slave modport is the sequencer's view; master is the environment's.
interface lsu_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  // decode/execute request
  logic                  req_valid;
  logic                  req_ready;
  logic [4:0]            req_opcode;
  logic [2:0]            req_f3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [4:0]            req_rd;
  // single-outstanding data bus
  logic                  bus_valid;
  logic                  bus_ready;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  bus_wen;
  logic [3:0]            bus_be;
  logic [31:0]           bus_wdata;
  logic                  bus_rvalid;
  logic [31:0]           bus_rdata;
  // writeback response
  logic                  resp_valid;
  logic [4:0]            resp_rd;
  logic [31:0]           resp_data;
  logic                  resp_err;
  logic                  busy;

  modport slave (
    input  req_valid, req_opcode, req_f3, req_addr, req_wdata, req_rd,
    input  bus_ready, bus_rvalid, bus_rdata,
    output req_ready, bus_valid, bus_addr, bus_wen, bus_be, bus_wdata,
    output resp_valid, resp_rd, resp_data, resp_err, busy
  );

  modport master (
    output req_valid, req_opcode, req_f3, req_addr, req_wdata, req_rd,
    output bus_ready, bus_rvalid, bus_rdata,
    input  req_ready, bus_valid, bus_addr, bus_wen, bus_be, bus_wdata,
    input  resp_valid, resp_rd, resp_data, resp_err, busy
  );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store sequencer: validates one request at a time, runs a single
// word-addressed bus transaction and returns an extended load result or a
// store completion. Every output comes straight from a register.
module lsu_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input logic       clock,
  input logic       reset_n,
  lsu_ctrl_if.slave lsu
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  typedef enum logic [1:0] {IDLE, ADDR, RDATA, RESP} state_t;

  state_t                state_q, state_d;
  logic                  store_q, store_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [4:0]            rd_q, rd_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;
  logic                  bus_valid_q, bus_valid_d;
  logic                  bus_wen_q, bus_wen_d;
  logic [3:0]            bus_be_q, bus_be_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]           bus_wdata_q, bus_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [4:0]            resp_rd_q, resp_rd_d;
  logic [31:0]           resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;

  logic                  is_load, is_store, illegal, misaligned;

  // Byte lanes touched by an access of size f3[1:0] at byte offset off.
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << {off[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Replicate the low store bytes into every lane so the byte enables pick them.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3[1:0])
      2'b00:   lane_wdata = {4{wdata[7:0]}};
      2'b01:   lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  // Shift the addressed lane down and sign/zero-extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_extract = {24'd0, sh[7:0]};
      3'b101:  load_extract = {16'd0, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  // Request decode: legal opcode/funct3 pairs and natural alignment.
  always_comb begin
    is_load    = (lsu.req_opcode == OP_LOAD);
    is_store   = (lsu.req_opcode == OP_STORE);
    illegal    = !(is_load || is_store)
               || (is_load && (lsu.req_f3 == 3'b011 || lsu.req_f3[2:1] == 2'b11))
               || (is_store && lsu.req_f3 >= 3'b011);
    misaligned = (lsu.req_f3[1:0] == 2'b01 && lsu.req_addr[0])
               || (lsu.req_f3[1:0] == 2'b10 && lsu.req_addr[1:0] != 2'b00);
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    bus_wen_d   = bus_wen_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    resp_rd_d   = resp_rd_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    case (state_q)
      IDLE: begin
        if (lsu.req_valid && req_ready_q) begin
          store_d = is_store;
          f3_d    = lsu.req_f3;
          off_d   = lsu.req_addr[1:0];
          rd_d    = lsu.req_rd;
          if (illegal || misaligned) begin
            state_d     = RESP;
            resp_err_d  = 1'b1;
            resp_rd_d   = 5'd0;
            resp_data_d = 32'd0;
          end else begin
            state_d     = ADDR;
            bus_addr_d  = {lsu.req_addr[ADDR_WIDTH-1:2], 2'b00};
            bus_wen_d   = is_store;
            bus_be_d    = lane_be(lsu.req_f3, lsu.req_addr[1:0]);
            bus_wdata_d = is_store ? lane_wdata(lsu.req_f3, lsu.req_wdata) : 32'd0;
          end
        end
      end
      ADDR: begin
        if (lsu.bus_ready) begin
          if (store_q) begin
            state_d     = RESP;
            resp_err_d  = 1'b0;
            resp_rd_d   = 5'd0;
            resp_data_d = 32'd0;
          end else begin
            state_d = RDATA;
          end
        end
      end
      RDATA: begin
        if (lsu.bus_rvalid) begin
          state_d     = RESP;
          resp_err_d  = 1'b0;
          resp_rd_d   = rd_q;
          resp_data_d = load_extract(f3_q, off_q, lsu.bus_rdata);
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    bus_valid_d  = (state_d == ADDR);
    resp_valid_d = (state_d == RESP);
  end

  // State and output registers; reset clears everything and drops any request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      rd_q         <= 5'd0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      bus_valid_q  <= 1'b0;
      bus_wen_q    <= 1'b0;
      bus_be_q     <= 4'd0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= 5'd0;
      resp_data_q  <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      bus_valid_q  <= bus_valid_d;
      bus_wen_q    <= bus_wen_d;
      bus_be_q     <= bus_be_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign lsu.req_ready  = req_ready_q;
  assign lsu.busy       = busy_q;
  assign lsu.bus_valid  = bus_valid_q;
  assign lsu.bus_wen    = bus_wen_q;
  assign lsu.bus_be     = bus_be_q;
  assign lsu.bus_addr   = bus_addr_q;
  assign lsu.bus_wdata  = bus_wdata_q;
  assign lsu.resp_valid = resp_valid_q;
  assign lsu.resp_rd    = resp_rd_q;
  assign lsu.resp_data  = resp_data_q;
  assign lsu.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores with stalls, error requests,
// spurious read beats and reset during a load.
module tb_lsu_ctrl;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  lsu_ctrl_if #(.ADDR_WIDTH(32)) lif ();

  lsu_ctrl #(.ADDR_WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .lsu     (lif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(lif.req_ready), 32'd0);
    chk({tag, "_busy"},      32'(lif.busy),      32'd0);
    chk({tag, "_bus_valid"}, 32'(lif.bus_valid), 32'd0);
    chk({tag, "_bus_wen"},   32'(lif.bus_wen),   32'd0);
    chk({tag, "_bus_be"},    32'(lif.bus_be),    32'd0);
    chk({tag, "_bus_addr"},  lif.bus_addr,       32'd0);
    chk({tag, "_bus_wdata"}, lif.bus_wdata,      32'd0);
    chk({tag, "_resp_vld"},  32'(lif.resp_valid), 32'd0);
    chk({tag, "_resp_rd"},   32'(lif.resp_rd),   32'd0);
    chk({tag, "_resp_data"}, lif.resp_data,      32'd0);
    chk({tag, "_resp_err"},  32'(lif.resp_err),  32'd0);
  endtask

  // Load with bus_ready at the first ADDR cycle and rvalid at the next one.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [3:0] be, input logic [31:0] exp);
    chk({tag, "_ready"}, 32'(lif.req_ready), 32'd1);
    lif.req_valid  = 1'b1;
    lif.req_opcode = 5'b00000;
    lif.req_f3     = f3;
    lif.req_addr   = addr;
    lif.req_rd     = rd;
    lif.req_wdata  = 32'hFFFF_FFFF;
    lif.bus_ready  = 1'b1;
    tick();
    lif.req_valid = 1'b0;
    chk({tag, "_bus_valid"}, 32'(lif.bus_valid), 32'd1);
    chk({tag, "_bus_addr"},  lif.bus_addr, {addr[31:2], 2'b00});
    chk({tag, "_bus_be"},    32'(lif.bus_be), 32'(be));
    chk({tag, "_bus_wen"},   32'(lif.bus_wen), 32'd0);
    chk({tag, "_busy"},      32'(lif.busy), 32'd1);
    tick();
    chk({tag, "_rdata_bus_valid"}, 32'(lif.bus_valid), 32'd0);
    chk({tag, "_rdata_resp_vld"},  32'(lif.resp_valid), 32'd0);
    lif.bus_ready  = 1'b0;
    lif.bus_rvalid = 1'b1;
    lif.bus_rdata  = rdata;
    tick();
    lif.bus_rvalid = 1'b0;
    chk({tag, "_resp_vld"},  32'(lif.resp_valid), 32'd1);
    chk({tag, "_resp_data"}, lif.resp_data, exp);
    chk({tag, "_resp_rd"},   32'(lif.resp_rd), 32'(rd));
    chk({tag, "_resp_err"},  32'(lif.resp_err), 32'd0);
    tick();
    chk({tag, "_pulse_end"}, 32'(lif.resp_valid), 32'd0);
    chk({tag, "_hold_data"}, lif.resp_data, exp);
    chk({tag, "_idle_rdy"},  32'(lif.req_ready), 32'd1);
  endtask

  // Store with bus_ready held low for 'stall' ADDR cycles.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall,
                          input logic [3:0] be, input logic [31:0] exp_wdata);
    lif.req_valid  = 1'b1;
    lif.req_opcode = 5'b01000;
    lif.req_f3     = f3;
    lif.req_addr   = addr;
    lif.req_rd     = 5'd9;
    lif.req_wdata  = wdata;
    lif.bus_ready  = 1'b0;
    tick();
    lif.req_valid = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) lif.bus_ready = 1'b1;
      chk({tag, "_bus_valid"}, 32'(lif.bus_valid), 32'd1);
      chk({tag, "_bus_addr"},  lif.bus_addr, {addr[31:2], 2'b00});
      chk({tag, "_bus_be"},    32'(lif.bus_be), 32'(be));
      chk({tag, "_bus_wdata"}, lif.bus_wdata, exp_wdata);
      chk({tag, "_bus_wen"},   32'(lif.bus_wen), 32'd1);
      chk({tag, "_no_resp"},   32'(lif.resp_valid), 32'd0);
      tick();
    end
    lif.bus_ready = 1'b0;
    chk({tag, "_resp_vld"},  32'(lif.resp_valid), 32'd1);
    chk({tag, "_resp_rd"},   32'(lif.resp_rd), 32'd0);
    chk({tag, "_resp_data"}, lif.resp_data, 32'd0);
    chk({tag, "_resp_err"},  32'(lif.resp_err), 32'd0);
    chk({tag, "_bus_off"},   32'(lif.bus_valid), 32'd0);
    tick();
    chk({tag, "_pulse_end"}, 32'(lif.resp_valid), 32'd0);
    chk({tag, "_idle_rdy"},  32'(lif.req_ready), 32'd1);
  endtask

  // Illegal or misaligned request: error response one cycle after accept.
  task automatic do_err(input string tag, input logic [4:0] opcode, input logic [2:0] f3,
                        input logic [31:0] addr);
    lif.req_valid  = 1'b1;
    lif.req_opcode = opcode;
    lif.req_f3     = f3;
    lif.req_addr   = addr;
    lif.req_rd     = 5'd17;
    lif.req_wdata  = 32'hCAFE_F00D;
    lif.bus_ready  = 1'b1;
    tick();
    lif.req_valid = 1'b0;
    chk({tag, "_resp_vld"},  32'(lif.resp_valid), 32'd1);
    chk({tag, "_resp_err"},  32'(lif.resp_err), 32'd1);
    chk({tag, "_resp_data"}, lif.resp_data, 32'd0);
    chk({tag, "_resp_rd"},   32'(lif.resp_rd), 32'd0);
    chk({tag, "_bus_valid"}, 32'(lif.bus_valid), 32'd0);
    tick();
    lif.bus_ready = 1'b0;
    chk({tag, "_pulse_end"}, 32'(lif.resp_valid), 32'd0);
    chk({tag, "_bus_valid2"}, 32'(lif.bus_valid), 32'd0);
    chk({tag, "_idle_rdy"},  32'(lif.req_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n        = 1'b0;
    lif.req_valid  = 1'b0;
    lif.req_opcode = 5'd0;
    lif.req_f3     = 3'd0;
    lif.req_addr   = 32'd0;
    lif.req_wdata  = 32'd0;
    lif.req_rd     = 5'd0;
    lif.bus_ready  = 1'b0;
    lif.bus_rvalid = 1'b0;
    lif.bus_rdata  = 32'd0;

    #2;
    chk_all_zero("por");
    tick();
    tick();
    #2 reset_n = 1'b1;
    chk(" rdy_before_edge", 32'(lif.req_ready), 32'd0);
    tick();
    chk("rdy_after_edge", 32'(lif.req_ready), 32'd1);
    chk("busy_idle", 32'(lif.busy), 32'd0);

    do_load("lw",  3'b010, 32'h0000_0100, 5'd5,  32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load("lb",  3'b000, 32'h0000_0103, 5'd6,  32'h8011_2233, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0103, 5'd7,  32'h8011_2233, 4'b1000, 32'h0000_0080);
    do_load("lb1", 3'b000, 32'h0000_0101, 5'd8,  32'h8011_2233, 4'b0010, 32'h0000_0022);
    do_load("lh",  3'b001, 32'h0000_0102, 5'd10, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_0102, 5'd11, 32'h8001_0000, 4'b1100, 32'h0000_8001);

    do_store("sh", 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 4'b1100, 32'hABCD_ABCD);
    do_store("sb", 3'b000, 32'h0000_0301, 32'h0000_00A5, 0, 4'b0010, 32'hA5A5_A5A5);
    do_store("sw", 3'b010, 32'h0000_0400, 32'h0102_0304, 1, 4'b1111, 32'h0102_0304);

    do_err("lw_mis",  5'b00000, 3'b010, 32'h0000_0101);
    do_err("ld_f3",   5'b00000, 3'b011, 32'h0000_0100);
    do_err("opimm",   5'b00100, 3'b000, 32'h0000_0100);
    do_err("st_f3",   5'b01000, 3'b011, 32'h0000_0100);
    do_err("sh_mis",  5'b01000, 3'b001, 32'h0000_0201);

    // spurious read beats in IDLE and in the handshake cycle
    lif.bus_rvalid = 1'b1;
    lif.bus_rdata  = 32'h1111_1111;
    tick();
    chk("spur_idle_resp", 32'(lif.resp_valid), 32'd0);
    chk("spur_idle_busy", 32'(lif.busy), 32'd0);
    lif.req_valid  = 1'b1;
    lif.req_opcode = 5'b00000;
    lif.req_f3     = 3'b010;
    lif.req_addr   = 32'h0000_0300;
    lif.req_rd     = 5'd7;
    lif.bus_ready  = 1'b1;
    lif.bus_rdata  = 32'h2222_2222;
    tick();
    lif.req_valid = 1'b0;
    chk("spur_addr_bus_valid", 32'(lif.bus_valid), 32'd1);
    tick();
    lif.bus_ready  = 1'b0;
    lif.bus_rvalid = 1'b0;
    chk("spur_hs_resp", 32'(lif.resp_valid), 32'd0);
    tick();
    chk("spur_wait_resp", 32'(lif.resp_valid), 32'd0);
    chk("spur_wait_busy", 32'(lif.busy), 32'd1);
    lif.bus_rvalid = 1'b1;
    lif.bus_rdata  = 32'h3333_3333;
    tick();
    lif.bus_rvalid = 1'b0;
    chk("spur_resp_vld",  32'(lif.resp_valid), 32'd1);
    chk("spur_resp_data", lif.resp_data, 32'h3333_3333);
    chk("spur_resp_rd",   32'(lif.resp_rd), 32'd7);
    tick();

    // reset while waiting for read data
    lif.req_valid  = 1'b1;
    lif.req_opcode = 5'b00000;
    lif.req_f3     = 3'b010;
    lif.req_addr   = 32'h0000_0100;
    lif.req_rd     = 5'd3;
    lif.bus_ready  = 1'b1;
    tick();
    lif.req_valid = 1'b0;
    tick();
    lif.bus_ready = 1'b0;
    chk("rst_in_rdata_busy", 32'(lif.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    tick();
    chk("rst_held_rdy", 32'(lif.req_ready), 32'd0);
    #2 reset_n = 1'b1;
    lif.bus_rvalid = 1'b1;
    lif.bus_rdata  = 32'h0BAD_0BAD;
    tick();
    lif.bus_rvalid = 1'b0;
    chk("rst_late_rvalid", 32'(lif.resp_valid), 32'd0);
    chk("rst_rel_rdy",     32'(lif.req_ready), 32'd1);
    chk("rst_rel_busy",    32'(lif.busy), 32'd0);
    do_load("post_rst", 3'b010, 32'h0000_0104, 5'd12, 32'h5A5A_0F0F, 4'b1111, 32'h5A5A_0F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
